light_phase_controller: RTL and testbench

LIGHT_PHASE_CONTROLLER -- requirements
Module: light_phase_controller

---
 rtl/rlgl_pkg.sv | 39 +++
 rtl/phase_timer.sv | 36 +++
 rtl/light_phase_controller.sv | 147 ++++++++++++++
 tb/tb_light_phase_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rlgl_pkg.sv
// Shared types for the red-light/green-light phase controller:
// light encoding, controller states and the LFSR seed/step.
package rlgl_pkg;

    typedef enum logic [1:0] {
        L_OFF    = 2'd0,
        L_GREEN  = 2'd1,
        L_YELLOW = 2'd2,
        L_RED    = 2'd3
    } light_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_RED_GRACE,
        S_RED_ARMED,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fibonacci LFSR, taps 8,6,5,4 (maximal length, never reaches zero)
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic light_t light_of(input state_t s);
        unique case (s)
            S_GREEN:     return L_GREEN;
            S_YELLOW:    return L_YELLOW;
            S_RED_GRACE: return L_RED;
            S_RED_ARMED: return L_RED;
            default:     return L_OFF;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick down-counter: loads a length, counts ticks to zero
// and flags expiry so the controller can advance.
module phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       tick_i,
    output logic [7:0] value_o,
    output logic       expired_o
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (tick_i && value_q != 8'd0) begin
            value_d = value_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 8'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o   = value_q;
    assign expired_o = (value_q == 8'd0);

endmodule

// File: rtl/light_phase_controller.sv
// Red-light/green-light round controller: phase sequencing, red-light
// movement policing, lives bookkeeping and win/lose result.
module light_phase_controller
    import rlgl_pkg::*;
#(
    parameter int GREEN_BASE   = 120,
    parameter int YELLOW_TICKS = 60,
    parameter int RED_TICKS    = 180,
    parameter int GRACE_TICKS  = 15,
    parameter int LIVES        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic       moved,
    input  logic       finish,
    output logic [1:0] light,
    output logic       detect_en,
    output logic       violation,
    output logic [2:0] lives_left,
    output logic       win,
    output logic       lose,
    output logic [7:0] ticks_left
);

    localparam logic [7:0] Y_LEN = 8'(YELLOW_TICKS - 1);
    localparam logic [7:0] G_LEN = 8'(GRACE_TICKS - 1);
    localparam logic [7:0] A_LEN = 8'(RED_TICKS - GRACE_TICKS - 1);
    localparam logic [7:0] B_LEN = 8'(GREEN_BASE - 1);

    state_t     state_q, state_d;
    logic [7:0] lfsr_q;
    logic       pen_q, pen_d;
    logic [2:0] lives_q, lives_d, lives_n;
    logic       viol_q, viol_d;
    light_t     light_q;
    logic       det_q, win_q, lose_q;
    logic       hit, active;
    logic       t_load, t_tick, t_exp;
    logic [7:0] t_val, green_len;

    assign active = (state_q == S_GREEN) || (state_q == S_YELLOW) ||
                    (state_q == S_RED_GRACE) || (state_q == S_RED_ARMED);
    assign green_len = B_LEN + {4'd0, lfsr_q[3:0]};

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        pen_d   = pen_q;
        viol_d  = 1'b0;
        hit     = 1'b0;
        lives_n = lives_q;
        t_load  = 1'b0;
        t_tick  = 1'b0;
        t_val   = 8'd0;
        if (!active) begin
            if (start) begin
                state_d = S_GREEN;
                lives_d = 3'(LIVES);
                t_load  = 1'b1;
                t_val   = green_len;
            end
        end else if (lives_q == 3'd0) begin
            // last life went on the previous cycle's violation
            state_d = S_LOSE;
            t_load  = 1'b1;
        end else begin
            hit     = (state_q == S_RED_ARMED) && moved && !pen_q;
            lives_n = lives_q - 3'(hit);
            viol_d  = hit;
            lives_d = lives_n;
            pen_d   = pen_q | hit;
            if (finish && lives_n != 3'd0) begin
                state_d = S_WIN;
                t_load  = 1'b1;
            end else if (tick && t_exp) begin
                t_load = 1'b1;
                unique case (state_q)
                    S_GREEN: begin
                        state_d = S_YELLOW;
                        t_val   = Y_LEN;
                    end
                    S_YELLOW: begin
                        state_d = S_RED_GRACE;
                        t_val   = G_LEN;
                    end
                    S_RED_GRACE: begin
                        state_d = S_RED_ARMED;
                        t_val   = A_LEN;
                    end
                    default: begin
                        state_d = S_GREEN;
                        t_val   = green_len;
                    end
                endcase
            end else begin
                t_tick = tick;
            end
        end
        if (state_d != S_RED_ARMED) begin
            pen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            pen_q   <= 1'b0;
            lives_q <= 3'(LIVES);
            viol_q  <= 1'b0;
            light_q <= L_OFF;
            det_q   <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_step(lfsr_q);
            pen_q   <= pen_d;
            lives_q <= lives_d;
            viol_q  <= viol_d;
            light_q <= light_of(state_d);
            det_q   <= (state_d == S_RED_ARMED);
            win_q   <= (state_d == S_WIN);
            lose_q  <= (state_d == S_LOSE);
        end
    end

    phase_timer u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (t_load),
        .load_val_i (t_val),
        .tick_i     (t_tick),
        .value_o    (ticks_left),
        .expired_o  (t_exp)
    );

    assign light      = light_q;
    assign detect_en  = det_q;
    assign violation  = viol_q;
    assign lives_left = lives_q;
    assign win        = win_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_light_phase_controller.sv
// Bench for light_phase_controller: directed round scenarios plus a
// random stretch, checked every cycle against a phase-level model.
module tb_light_phase_controller;

    localparam int GB = 4;
    localparam int YT = 2;
    localparam int RT = 6;
    localparam int GT = 2;
    localparam int LV = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       moved = 1'b0;
    logic       finish = 1'b0;
    logic [1:0] light;
    logic       detect_en;
    logic       violation;
    logic [2:0] lives_left;
    logic       win;
    logic       lose;
    logic [7:0] ticks_left;

    int vectors = 0;
    int errs = 0;
    int tcnt = 0;

    // model: phase 0 idle, 1 green, 2 yellow, 3 red grace, 4 red armed, 5 win, 6 lose
    int         m_ph, m_rem, m_lv, m_pen, m_vio, m_pend;
    logic [7:0] m_lf;

    light_phase_controller #(
        .GREEN_BASE   (GB),
        .YELLOW_TICKS (YT),
        .RED_TICKS    (RT),
        .GRACE_TICKS  (GT),
        .LIVES        (LV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tick       (tick),
        .moved      (moved),
        .finish     (finish),
        .light      (light),
        .detect_en  (detect_en),
        .violation  (violation),
        .lives_left (lives_left),
        .win        (win),
        .lose       (lose),
        .ticks_left (ticks_left)
    );

    always #5 clk = ~clk;

    function automatic int plen(input int ph, input logic [7:0] lf);
        case (ph)
            1:       return GB + int'(lf[3:0]) - 1;
            2:       return YT - 1;
            3:       return GT - 1;
            4:       return RT - GT - 1;
            default: return 0;
        endcase
    endfunction

    function automatic int lt(input int ph);
        case (ph)
            1:       return 1;
            2:       return 2;
            3, 4:    return 3;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_rem = 0; m_lv = LV; m_pen = 0; m_vio = 0; m_pend = 0;
        m_lf = 8'hA5;
    endtask

    // what the next clock edge must produce, given the inputs now applied
    task automatic model_step();
        logic [7:0] lf_now;
        lf_now = m_lf;
        m_lf = {m_lf[6:0], m_lf[7] ^ m_lf[5] ^ m_lf[4] ^ m_lf[3]};
        m_vio = 0;
        if (m_ph == 0 || m_ph >= 5) begin
            if (start) begin
                m_ph = 1; m_lv = LV; m_rem = plen(1, lf_now); m_pen = 0; m_pend = 0;
            end
        end else if (m_pend != 0) begin
            m_ph = 6; m_rem = 0; m_pend = 0;
        end else begin
            if (m_ph == 4 && moved && m_pen == 0) begin
                m_vio = 1; m_lv--; m_pen = 1; m_pend = (m_lv == 0) ? 1 : 0;
            end
            if (finish && m_lv > 0) begin
                m_ph = 5; m_rem = 0;
            end else if (tick) begin
                if (m_rem == 0) begin
                    m_ph  = (m_ph == 4) ? 1 : m_ph + 1;
                    m_rem = plen(m_ph, lf_now);
                end else begin
                    m_rem--;
                end
            end
        end
        if (m_ph != 4) m_pen = 0;
    endtask

    task automatic check_all();
        chk("light", 32'(light), 32'(lt(m_ph)));
        chk("detect_en", 32'(detect_en), 32'(m_ph == 4));
        chk("violation", 32'(violation), 32'(m_vio));
        chk("lives_left", 32'(lives_left), 32'(m_lv));
        chk("win", 32'(win), 32'(m_ph == 5));
        chk("lose", 32'(lose), 32'(m_ph == 6));
        chk("ticks_left", 32'(ticks_left), 32'(m_rem));
    endtask

    task automatic step(input bit mv, input bit fin, input bit st);
        moved  = mv;
        finish = fin;
        start  = st;
        tick   = (tcnt % 4 == 3);
        tcnt++;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_until(input int target, input bit mv);
        int n;
        n = 0;
        while (m_ph == target && n < 300) begin
            step(mv, 1'b0, 1'b0);
            n++;
        end
        while (m_ph != target && n < 300) begin
            step(mv, 1'b0, 1'b0);
            n++;
        end
        chk("reach_phase", 32'(lt(m_ph)), 32'(lt(target)));
        if (m_ph != target) begin
            vectors++;
            errs++;
            $display("FAIL reach: phase %0d, required %0d", m_ph, target);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_light"}, 32'(light), 32'd0);
        chk({tag, "_detect"}, 32'(detect_en), 32'd0);
        chk({tag, "_viol"}, 32'(violation), 32'd0);
        chk({tag, "_lives"}, 32'(lives_left), 32'(LV));
        chk({tag, "_win"}, 32'(win), 32'd0);
        chk({tag, "_lose"}, 32'(lose), 32'd0);
        chk({tag, "_ticks"}, 32'(ticks_left), 32'd0);
    endtask

    initial begin
        int vcount;
        int gcount;
        int n;
        #1 reset = 1'b0;
        model_reset();
        #3;
        chk_reset("por");
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0);
        step(0, 1, 0);

        // start: green next cycle with full lives and a randomised green length
        step(0, 0, 1);
        chk("start_light", 32'(light), 32'd1);
        chk("start_lives", 32'(lives_left), 32'd3);
        chk("start_range", 32'(ticks_left >= 8'd3 && ticks_left <= 8'd18), 32'd1);

        // movement during grace is free; held through armed red costs one life
        run_until(3, 0);
        vcount = 0;
        gcount = 0;
        n = 0;
        while (m_ph == 3 && n < 50) begin
            step(1, 0, 0);
            if (m_ph == 3 && violation) gcount++;
            n++;
        end
        while (m_ph == 4 && n < 100) begin
            if (violation) vcount++;
            step(1, 0, 0);
            n++;
        end
        chk("grace_viols", 32'(gcount), 32'd0);
        chk("armed_viols", 32'(vcount), 32'd1);
        chk("armed_lives", 32'(lives_left), 32'd2);

        // two more penalised red phases end the round
        run_until(4, 0);
        step(1, 0, 0);
        chk("v2_lives", 32'(lives_left), 32'd1);
        run_until(4, 0);
        step(1, 0, 0);
        chk("v3_viol", 32'(violation), 32'd1);
        chk("v3_lives", 32'(lives_left), 32'd0);
        step(0, 0, 0);
        chk("v3_lose", 32'(lose), 32'd1);
        chk("v3_light", 32'(light), 32'd0);
        step(1, 1, 0);
        chk("lose_hold", 32'(lose), 32'd1);

        // finish in yellow wins
        step(0, 0, 1);
        run_until(2, 0);
        step(0, 1, 0);
        chk("y_win", 32'(win), 32'd1);
        chk("y_win_ticks", 32'(ticks_left), 32'd0);

        // finish with moved on the last life: violation wins over finish
        step(0, 0, 1);
        run_until(4, 0);
        step(1, 0, 0);
        run_until(4, 0);
        step(1, 0, 0);
        chk("l1_lives", 32'(lives_left), 32'd1);
        run_until(4, 0);
        step(1, 1, 0);
        chk("fm_win", 32'(win), 32'd0);
        chk("fm_viol", 32'(violation), 32'd1);
        step(0, 0, 0);
        chk("fm_lose", 32'(lose), 32'd1);
        chk("fm_win2", 32'(win), 32'd0);

        // random play
        for (int i = 0; i < 900; i++) begin
            step(($urandom % 6) == 0, ($urandom % 60) == 0, ($urandom % 25) == 0);
        end

        // asynchronous abort mid-armed-red
        step(0, 0, 1);
        if (m_ph == 0 || m_ph >= 5) step(0, 0, 1);
        run_until(4, 1);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk_reset("arst");
        @(posedge clk);
        #1;
        chk_reset("arst_hold");
        @(negedge clk);
        reset = 1'b1;
        step(1, 0, 0);
        step(0, 0, 1);
        chk("rs_light", 32'(light), 32'd1);
        chk("rs_lives", 32'(lives_left), 32'd3);
        run_until(4, 0);
        step(1, 0, 0);
        chk("rs_lives2", 32'(lives_left), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
